// File: rtl/pipe_control_gen_pkg.sv
// Opcode constants, mem_state encodings and FSM states shared by the pipeline controller.
// Pure definitions: no logic, no latency, no flow control.
package pipe_control_gen_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_WRITE = 2'd1;
  localparam logic [1:0] MS_IND   = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  typedef enum logic [2:0] {
    S_FILL,
    S_RUN,
    S_MEM_IND,
    S_MEM_ACC,
    S_BR_WAIT,
    S_BR_BUBBLE
  } state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/pipe_bypass_detect.sv
// Operand-forwarding detection between execute and decode; selects are registered and
// advance only with the decode enable (one-cycle latency, hold while decode is stalled).
module pipe_bypass_detect
  import pipe_control_gen_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_ir,
  input  logic [15:0] i_ir_exec,
  output logic        o_bypass_alu_1,
  output logic        o_bypass_alu_2,
  output logic        o_bypass_mem_1
);

  logic [3:0] w_op_dec;
  logic [3:0] w_op_exec;
  logic       w_dst_eq_sr1;
  logic       w_dst_eq_sr2;
  logic       w_alu_1;
  logic       w_alu_2;
  logic       w_mem_1;
  logic       r_alu_1;
  logic       r_alu_2;
  logic       r_mem_1;

  assign w_op_dec     = i_ir[15:12];
  assign w_op_exec    = i_ir_exec[15:12];
  assign w_dst_eq_sr1 = (i_ir_exec[11:9] == i_ir[8:6]);
  assign w_dst_eq_sr2 = (i_ir_exec[11:9] == i_ir[2:0]);

  // SR2 only exists for register-mode ADD/AND; immediate mode reuses those bits.
  assign w_alu_1 = is_alu(w_op_exec) && w_dst_eq_sr1;
  assign w_alu_2 = is_alu(w_op_exec) && ((w_op_dec == OP_ADD) || (w_op_dec == OP_AND))
                   && !i_ir[5] && w_dst_eq_sr2;
  assign w_mem_1 = is_load(w_op_exec) && w_dst_eq_sr1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_1 <= 1'b0;
      r_alu_2 <= 1'b0;
      r_mem_1 <= 1'b0;
    end else if (i_en) begin
      r_alu_1 <= w_alu_1;
      r_alu_2 <= w_alu_2;
      r_mem_1 <= w_mem_1;
    end
  end

  assign o_bypass_alu_1 = r_alu_1;
  assign o_bypass_alu_2 = r_alu_2;
  assign o_bypass_mem_1 = r_mem_1;

endmodule

// File: rtl/pipe_control_gen.sv
// Pipeline stage-enable controller: fill sequencing, memory and branch stalls; enables are same-cycle
// (Mealy) on complete_instr/complete_data. Bypass selects exist only with PIPE_CONTROL_GEN_BYPASS_EN.
module pipe_control_gen
  import pipe_control_gen_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic [1:0]  mem_state
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_fill;
  logic       r_exec_q;
  logic       r_wb_q;
  logic       r_mem_done;
  logic       r_br_done;
  logic [3:0] w_op_dec;
  logic [3:0] w_op_exec;
  logic       w_exec_is_mem;
  logic       w_dec_is_br;
  logic       w_br_cond;

  assign w_op_dec      = IR[15:12];
  assign w_op_exec     = IR_Exec[15:12];
  assign w_exec_is_mem = is_load(w_op_exec) || is_store(w_op_exec);
  assign w_dec_is_br   = (w_op_dec == OP_BR) || (w_op_dec == OP_JMP);
  assign w_br_cond     = (|(NZP & psr)) || (w_op_exec == OP_JMP);

  // r_mem_done / r_br_done stop a serviced instruction, still sitting in its stage, from re-triggering.
  always_comb begin
    w_state_nxt      = r_state;
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    mem_state        = MS_IDLE;
    case (r_state)
      S_FILL: begin
        enable_updatePC  = (r_fill != 2'd0);
        enable_fetch     = (r_fill != 2'd0);
        enable_decode    = r_fill[1];
        enable_execute   = (r_fill == 2'd3);
        enable_writeback = (r_fill == 2'd3);
        if (r_fill == 2'd3) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_exec_is_mem && !r_mem_done) begin
          w_state_nxt = ((w_op_exec == OP_LDI) || (w_op_exec == OP_STI)) ? S_MEM_IND : S_MEM_ACC;
        end else if (w_dec_is_br && !r_br_done) begin
          enable_execute   = 1'b1;
          enable_writeback = 1'b1;
          w_state_nxt      = S_BR_WAIT;
        end else if (complete_instr) begin
          enable_updatePC  = 1'b1;
          enable_fetch     = 1'b1;
          enable_decode    = 1'b1;
          enable_execute   = 1'b1;
          enable_writeback = 1'b1;
        end else begin
          enable_execute   = r_exec_q;
          enable_writeback = r_wb_q;
        end
      end
      S_MEM_IND: begin
        mem_state = MS_IND;
        if (complete_data) w_state_nxt = S_MEM_ACC;
      end
      S_MEM_ACC: begin
        mem_state = is_load(w_op_exec) ? MS_READ : MS_WRITE;
        if (complete_data) begin
          enable_writeback = is_load(w_op_exec);
          w_state_nxt      = S_RUN;
        end
      end
      S_BR_WAIT: begin
        br_taken    = w_br_cond;
        w_state_nxt = S_BR_BUBBLE;
      end
      S_BR_BUBBLE: w_state_nxt = S_RUN;
      default:     w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_FILL;
      r_fill     <= 2'd0;
      r_exec_q   <= 1'b0;
      r_wb_q     <= 1'b0;
      r_mem_done <= 1'b0;
      r_br_done  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_exec_q <= enable_execute;
      r_wb_q   <= enable_writeback;
      if ((r_state == S_FILL) && (r_fill != 2'd3)) r_fill <= r_fill + 2'd1;
      if ((r_state == S_MEM_ACC) && complete_data) r_mem_done <= 1'b1;
      else if (enable_execute)                     r_mem_done <= 1'b0;
      if (r_state == S_BR_BUBBLE)  r_br_done <= 1'b1;
      else if (enable_decode)      r_br_done <= 1'b0;
    end
  end

`ifdef PIPE_CONTROL_GEN_BYPASS_EN
  pipe_bypass_detect u_bypass (
    .i_clk          (clock),
    .i_rst          (reset),
    .i_en           (enable_decode),
    .i_ir           (IR),
    .i_ir_exec      (IR_Exec),
    .o_bypass_alu_1 (bypass_alu_1),
    .o_bypass_alu_2 (bypass_alu_2),
    .o_bypass_mem_1 (bypass_mem_1)
  );
`else
  logic w_unused_ir_bits;
  assign w_unused_ir_bits = ^{IR[11:0], IR_Exec[11:0]};
  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
  assign bypass_mem_1 = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_gen.sv
// Directed bench for pipe_control_gen: per-cycle vector table plus reset/bypass sequences.
module tb_pipe_control_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        complete_data = 1'b0;
  logic        complete_instr = 1'b1;
  logic [15:0] IR = 16'hE000;
  logic [15:0] IR_Exec = 16'hE000;
  logic [2:0]  NZP = 3'd0;
  logic [2:0]  psr = 3'd0;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1;
  logic [1:0]  mem_state;
  logic [4:0]  w_en;
  logic [2:0]  w_byp;

`ifdef PIPE_CONTROL_GEN_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic [15:0] D = 16'hE000;

  pipe_control_gen dut (
    .clock(clock), .reset(reset), .complete_data(complete_data), .complete_instr(complete_instr),
    .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .bypass_mem_1(bypass_mem_1),
    .mem_state(mem_state)
  );

  always #5 clock = ~clock;

  assign w_en  = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
  assign w_byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1};

  typedef struct {
    logic        ci;
    logic        cd;
    logic [15:0] ir;
    logic [15:0] ire;
    logic [2:0]  nzp;
    logic [2:0]  psr;
    logic [4:0]  en;
    logic        br;
    logic [1:0]  ms;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic ci, input logic cd, input logic [15:0] ir,
                              input logic [15:0] ire, input logic [2:0] nzp, input logic [2:0] ps,
                              input logic [4:0] en, input logic br, input logic [1:0] ms);
    vec_t v;
    v.ci = ci; v.cd = cd; v.ir = ir; v.ire = ire; v.nzp = nzp; v.psr = ps;
    v.en = en; v.br = br; v.ms = ms;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ci, input logic cd, input logic [15:0] ir, input logic [15:0] ire,
                       input logic [2:0] nzp, input logic [2:0] ps);
    complete_instr = ci; complete_data = cd; IR = ir; IR_Exec = ire; NZP = nzp; psr = ps;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_en"}, {27'd0, w_en}, 32'd0);
    chk({nm, "_br"}, {31'd0, br_taken}, 32'd0);
    chk({nm, "_ms"}, {30'd0, mem_state}, 32'd3);
    chk({nm, "_byp"}, {29'd0, w_byp}, 32'd0);
  endtask

  initial begin
    // fill, run/hold, LDR with 3 waits, LDI, BR taken/not taken, JMP, mem-before-branch
    vq.push_back(mk(1,0,D,D,0,0, 5'b00000,0,3));
    vq.push_back(mk(1,0,D,D,0,0, 5'b11000,0,3));
    vq.push_back(mk(1,0,D,D,0,0, 5'b11100,0,3));
    vq.push_back(mk(1,0,D,D,0,0, 5'b11111,0,3));
    vq.push_back(mk(1,0,D,D,0,0, 5'b11111,0,3));
    vq.push_back(mk(0,0,D,D,0,0, 5'b00011,0,3));
    vq.push_back(mk(1,0,D,16'h6000,0,0, 5'b00000,0,3));
    vq.push_back(mk(1,0,D,16'h6000,0,0, 5'b00000,0,0));
    vq.push_back(mk(1,0,D,16'h6000,0,0, 5'b00000,0,0));
    vq.push_back(mk(1,0,D,16'h6000,0,0, 5'b00000,0,0));
    vq.push_back(mk(1,1,D,16'h6000,0,0, 5'b00001,0,0));
    vq.push_back(mk(1,0,D,16'h6000,0,0, 5'b11111,0,3));
    vq.push_back(mk(1,0,D,16'hA000,0,0, 5'b00000,0,3));
    vq.push_back(mk(1,1,D,16'hA000,0,0, 5'b00000,0,2));
    vq.push_back(mk(1,1,D,16'hA000,0,0, 5'b00001,0,0));
    vq.push_back(mk(1,0,D,16'hA000,0,0, 5'b11111,0,3));
    vq.push_back(mk(1,0,16'h0400,D,0,0, 5'b00011,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b010,3'b010, 5'b00000,1,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b010,3'b010, 5'b00000,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b010,3'b010, 5'b11111,0,3));
    vq.push_back(mk(1,0,16'h0400,D,3'b010,3'b100, 5'b00011,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b010,3'b100, 5'b00000,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b010,3'b100, 5'b00000,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b010,3'b100, 5'b11111,0,3));
    vq.push_back(mk(1,0,16'hC1C0,D,0,0, 5'b00011,0,3));
    vq.push_back(mk(1,0,16'hC1C0,16'hC1C0,0,0, 5'b00000,1,3));
    vq.push_back(mk(1,0,16'hC1C0,16'hC1C0,0,0, 5'b00000,0,3));
    vq.push_back(mk(1,0,16'hC1C0,16'hC1C0,0,0, 5'b11111,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h3000,0,0, 5'b00000,0,3));
    vq.push_back(mk(1,1,16'h0400,16'h3000,0,0, 5'b00000,0,1));
    vq.push_back(mk(1,0,16'h0400,16'h3000,0,0, 5'b00011,0,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b001,3'b001, 5'b00000,1,3));
    vq.push_back(mk(1,0,16'h0400,16'h0400,3'b001,3'b001, 5'b00000,0,3));
    vq.push_back(mk(1,0,D,D,0,0, 5'b11111,0,3));

    @(negedge clock);
    #1;
    chk_reset_vals("rst_init");
    @(negedge clock);
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].ci, vq[i].cd, vq[i].ir, vq[i].ire, vq[i].nzp, vq[i].psr);
      #1;
      chk($sformatf("v%0d_en", i), {27'd0, w_en}, {27'd0, vq[i].en});
      chk($sformatf("v%0d_br", i), {31'd0, br_taken}, {31'd0, vq[i].br});
      chk($sformatf("v%0d_ms", i), {30'd0, mem_state}, {30'd0, vq[i].ms});
      @(negedge clock);
    end

    // ADD R3 in execute, ADD R1,R3,R3 in decode
    drive(1, 0, 16'h12C3, 16'h16C2, 0, 0);
    @(negedge clock);
    chk("byp_add_reg", {29'd0, w_byp}, {29'd0, BYP, BYP, 1'b0});
    drive(0, 0, 16'h12C3, D, 0, 0);
    @(negedge clock);
    chk("byp_hold", {29'd0, w_byp}, {29'd0, BYP, BYP, 1'b0});
    // LD R3 in execute: forwarding is latched when decode resumes after the load
    drive(1, 0, 16'h12C3, 16'h2600, 0, 0);
    @(negedge clock);
    chk("ld_ms", {30'd0, mem_state}, 32'd0);
    chk("byp_hold_mem", {29'd0, w_byp}, {29'd0, BYP, BYP, 1'b0});
    drive(1, 1, 16'h12C3, 16'h2600, 0, 0);
    @(negedge clock);
    drive(1, 0, 16'h12C3, 16'h2600, 0, 0);
    #1;
    chk("ld_resume_en", {27'd0, w_en}, 32'h1F);
    @(negedge clock);
    chk("byp_ld", {29'd0, w_byp}, {29'd0, 1'b0, 1'b0, BYP});
    drive(1, 0, 16'h12E3, 16'h16C2, 0, 0);
    @(negedge clock);
    chk("byp_add_imm", {29'd0, w_byp}, {29'd0, BYP, 1'b0, 1'b0});

    // reset in the middle of a load access
    drive(1, 0, D, 16'h6000, 0, 0);
    @(negedge clock);
    chk("macc_ms", {30'd0, mem_state}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rst_macc");
    @(negedge clock);
    drive(1, 0, D, D, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("refill%0d_en", k), {27'd0, w_en},
          (k == 0) ? 32'h00 : (k == 1) ? 32'h18 : (k == 2) ? 32'h1C : 32'h1F);
      chk($sformatf("refill%0d_ms", k), {30'd0, mem_state}, 32'd3);
      @(negedge clock);
    end

    // reset while a taken branch is in BR_WAIT
    drive(1, 0, 16'h0400, D, 0, 0);
    #1;
    chk("brw_pre_en", {27'd0, w_en}, 32'h03);
    @(negedge clock);
    drive(1, 0, 16'h0400, 16'h0400, 3'b010, 3'b010);
    #1;
    chk("brw_br", {31'd0, br_taken}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("brw_rst_br", {31'd0, br_taken}, 32'd0);
    @(posedge clock);
    #1;
    chk_reset_vals("brw_rst_edge");
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("brw_post_br", {31'd0, br_taken}, 32'd0);
    chk("brw_post_en", {27'd0, w_en}, 32'd0);
    @(negedge clock);
    chk("brw_post_fill1", {27'd0, w_en}, 32'h18);
    chk("brw_post_br1", {31'd0, br_taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_control_gen.md
PIPE_CONTROL_GEN -- requirements
Module: pipe_control_gen

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports `clock` and `reset`; all state SHALL clear immediately on `reset`=1.
REQ-002 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 complete_data  in  1  data memory access finished this cycle.
REQ-005 complete_instr  in  1  instruction fetch finished this cycle.
REQ-006 IR  in  16  instruction in decode.
REQ-007 IR_Exec  in  16  instruction in execute.
REQ-008 NZP  in  3  branch condition mask of IR_Exec.
REQ-009 psr  in  3  current N/Z/P flags.
REQ-010 enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage advance enables.
REQ-011 br_taken  out  1  redirect PC this cycle.
REQ-012 bypass_alu_1, bypass_alu_2, bypass_mem_1  out  1 each  operand forwarding selects.
REQ-013 mem_state  out  2  0=read, 1=write, 2=indirect-address read, 3=idle.

Function
REQ-014 Pipeline fill: a 2-bit counter SHALL raise the enables one per cycle after reset release, each staying high: cycle 1 updatePC+fetch, cycle 2 decode, cycle 3 execute+writeback.
REQ-015 FSM states SHALL be FILL, RUN, MEM_IND, MEM_ACC, BR_WAIT, BR_BUBBLE.
REQ-016 RUN: all five enables SHALL be 1 only when complete_instr=1; otherwise updatePC, fetch and decode SHALL be 0 and execute/writeback hold their value.
REQ-017 If IR_Exec opcode is LD/LDR/ST/STR, RUN SHALL go to MEM_ACC; if LDI/STI, RUN SHALL go to MEM_IND.
REQ-018 MEM_IND: mem_state=2 and all enables 0. On complete_data=1 the FSM SHALL go to MEM_ACC; otherwise it holds.
REQ-019 MEM_ACC: mem_state=0 for loads and 1 for stores; all enables 0. On complete_data=1 the FSM SHALL return to RUN with writeback=1 for loads in that cycle; otherwise it holds.
REQ-020 Outside MEM_IND and MEM_ACC, mem_state SHALL be 3.
REQ-021 If IR opcode is BR (0000) or JMP (1100) in RUN, the next state SHALL be BR_WAIT, with updatePC, fetch and decode 0.
REQ-022 BR_WAIT: br_taken SHALL be 1 for exactly one cycle when (NZP & psr) != 0 or the opcode is JMP, then go to BR_BUBBLE. BR_BUBBLE is one cycle with execute=0, then the FSM SHALL return to RUN.
REQ-023 If a memory op in execute and a branch in decode coincide, the memory op SHALL be handled first; the branch SHALL be taken up afterwards in RUN.
REQ-024 bypass_alu_1 SHALL be 1 when IR_Exec is ADD/AND/NOT and IR_Exec[11:9]==IR[8:6].
REQ-025 bypass_alu_2 SHALL be 1 when IR_Exec is ADD/AND/NOT, IR is register-mode ADD/AND (IR[5]=0), and IR_Exec[11:9]==IR[2:0].
REQ-026 bypass_mem_1 SHALL be 1 when IR_Exec is LD/LDR/LDI and IR_Exec[11:9]==IR[8:6].
REQ-027 Bypass outputs SHALL be registered, updated only when enable_decode=1, and otherwise hold.

Reset
REQ-028 On reset: all enables 0, br_taken 0, all bypasses 0, mem_state 3, FSM=FILL, fill counter 0.
REQ-029 Reset asserted mid-MEM_ACC or mid-BR_WAIT SHALL abort the operation with no residual br_taken pulse.

Configuration
REQ-030 Macro PIPE_CONTROL_GEN_BYPASS_EN SHALL control the bypass logic.
- Defined: bypass logic per REQ-024..027.
- Undefined: the three bypass outputs are tied to 0 and the bypass sub-module is not instantiated.

Structure
REQ-031 Package pipe_control_gen_pkg SHALL hold the opcode constants, the mem_state encodings and the FSM state enum.
REQ-032 Bypass detection SHALL be a sub-module, pipe_bypass_detect, instantiated only under the macro.

Verification
REQ-033 Reset release, complete_instr=1 -> updatePC/fetch=1 at cycle 1, decode at 2, execute/writeback at 3; mem_state=3 throughout.
REQ-034 IR_Exec=LDR (0x6...), complete_data low for 3 cycles -> mem_state=0 for 4 cycles, enables 0, writeback=1 on the completing cycle.
REQ-035 IR_Exec=LDI -> mem_state 2 then 0; with complete_data=1 each cycle, back to RUN after 2 cycles.
REQ-036 IR=BR nzp=010 with psr=010 -> br_taken one-cycle pulse; with psr=100 -> no pulse; 3-cycle fetch stall in both cases.
REQ-037 IR_Exec=ADD R3 (0x16..), IR=ADD R1,R3,R3 (register mode) -> bypass_alu_1=bypass_alu_2=1; IR_Exec=LD R3 -> bypass_mem_1=1; all bypasses 0 when the macro is undefined.
REQ-038 Reset pulsed during MEM_ACC -> all outputs return to reset values asynchronously; FILL sequence restarts.
